// File: rtl/ex_branch_resolve.sv
// Execute-stage back end: resolves branches/JAL/JALR, forms link and redirect targets, registers EX/MEM entry.
// Latency: 1 cycle from accept to out_valid; redirect_valid pulses in the cycle after a taken accept.
// Backpressure: in_ready = ~out_valid | out_ready; a stalled entry holds every out_* stable.
//
// Optional build macro: MISALIGN_TRAP_EN -- adds out_exc; a taken transfer whose
// target[1] is set raises an exception entry instead of redirecting.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   EX instruction handshake
//   pc, imm, funct3       PC, sign-extended immediate, branch condition selector
//   is_branch/jal/jalr    control-transfer class (one-hot or all zero)
//   alu_result, alu_flags ALU result and {V,C,N,Z}
//   rd, reg_write         destination register and write enable
//   store_data            rs2 value for stores
//   mem_read, mem_write   memory operation flags
//   flush                 kill from a later stage
//   out_*                 EX/MEM pipeline register, handshake out_valid / out_ready
//   redirect_valid/pc     one-cycle fetch redirect and its target
//   out_exc               (MISALIGN_TRAP_EN only) misaligned control-transfer target

module ex_branch_resolve #(
  parameter int XLEN   = 32,
  parameter int SHADOW = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [2:0]      funct3,
  input  logic            is_branch,
  input  logic            is_jal,
  input  logic            is_jalr,
  input  logic [XLEN-1:0] alu_result,
  input  logic [3:0]      alu_flags,
  input  logic [4:0]      rd,
  input  logic            reg_write,
  input  logic [XLEN-1:0] store_data,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            out_reg_write,
  output logic [XLEN-1:0] out_store_data,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
`ifdef MISALIGN_TRAP_EN
  ,
  output logic            out_exc
`endif
);

  // Shadow counter is 3 bits wide: SHADOW is limited to 0..7.
  localparam int SW = 3;

  // Pipeline-register state.
  logic            out_valid_q,      out_valid_d;
  logic [XLEN-1:0] out_result_q,     out_result_d;
  logic [4:0]      out_rd_q,         out_rd_d;
  logic            out_reg_write_q,  out_reg_write_d;
  logic [XLEN-1:0] out_store_data_q, out_store_data_d;
  logic            out_mem_read_q,   out_mem_read_d;
  logic            out_mem_write_q,  out_mem_write_d;
  logic            redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0] redirect_pc_q,    redirect_pc_d;
  logic [SW-1:0]   shadow_q,         shadow_d;
`ifdef MISALIGN_TRAP_EN
  logic            out_exc_q,        out_exc_d;
`endif

  // Condition evaluation.
  logic            flag_v, flag_c, flag_n, flag_z;
  logic            cond;
  logic            is_link;
  logic            taken;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] link;
  logic            misalign;

  // Handshake qualifiers.
  logic            accept;
  logic            consume;
  logic            squash;
  logic            live;

  assign {flag_v, flag_c, flag_n, flag_z} = alu_flags;

  always_comb begin
    cond = 1'b0;
    unique case (funct3)
      3'b000:  cond = flag_z;                  // BEQ
      3'b001:  cond = ~flag_z;                 // BNE
      3'b100:  cond = flag_n ^ flag_v;         // BLT
      3'b101:  cond = ~(flag_n ^ flag_v);      // BGE
      3'b110:  cond = ~flag_c;                 // BLTU: borrow out of rs1-rs2
      3'b111:  cond = flag_c;                  // BGEU
      default: cond = 1'b0;                    // 010/011 are not branch encodings
    endcase
  end

  assign is_link = is_jal | is_jalr;
  assign taken   = is_link | (is_branch & cond);

  // JALR target comes from the ALU (rs1+imm) with bit 0 cleared; everything
  // else is PC-relative. Both sums wrap modulo 2^XLEN.
  assign target = is_jalr ? {alu_result[XLEN-1:1], 1'b0} : (pc + imm);
  assign link   = pc + XLEN'(4);

`ifdef MISALIGN_TRAP_EN
  assign misalign = taken & target[1];
`else
  assign misalign = 1'b0;
`endif

  assign in_ready = ~out_valid_q | out_ready;
  assign accept   = in_valid & in_ready;
  assign consume  = out_valid_q & out_ready;
  assign squash   = (shadow_q != '0);
  // An accepted instruction only becomes architecturally visible if it is
  // neither killed by a later stage nor sitting in a taken transfer's shadow.
  assign live     = accept & ~flush & ~squash;

  always_comb begin
    out_valid_d      = out_valid_q;
    out_result_d     = out_result_q;
    out_rd_d         = out_rd_q;
    out_reg_write_d  = out_reg_write_q;
    out_store_data_d = out_store_data_q;
    out_mem_read_d   = out_mem_read_q;
    out_mem_write_d  = out_mem_write_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    shadow_d         = shadow_q;
`ifdef MISALIGN_TRAP_EN
    out_exc_d        = out_exc_q;
`endif

    // Valid bit: flush beats accept beats consume. An accept always implies
    // the previous entry has left (in_ready), so a squashed accept leaves a bubble.
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = ~squash;
    end else if (consume) begin
      out_valid_d = 1'b0;
    end

    // Payload loads only for live accepts so a stalled entry stays stable.
    if (live) begin
      out_result_d     = is_link ? link : alu_result;
      out_rd_d         = rd;
      out_reg_write_d  = reg_write & ~is_branch;
      out_store_data_d = store_data;
      out_mem_read_d   = mem_read;
      out_mem_write_d  = mem_write;
`ifdef MISALIGN_TRAP_EN
      out_exc_d        = misalign;
      if (misalign) begin
        // Faulting entry reports the bad target and must not write rd.
        out_result_d    = target;
        out_reg_write_d = 1'b0;
      end
`endif
    end

    if (live & taken & ~misalign) begin
      redirect_valid_d = 1'b1;
      redirect_pc_d    = target;
    end

    // Shadow counter: flush clears it, squashed accepts count it down,
    // a redirecting accept arms it.
    if (flush) begin
      shadow_d = '0;
    end else if (accept & squash) begin
      shadow_d = shadow_q - SW'(1);
    end else if (live & taken & ~misalign) begin
      shadow_d = SW'(SHADOW);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q      <= 1'b0;
      out_result_q     <= '0;
      out_rd_q         <= '0;
      out_reg_write_q  <= 1'b0;
      out_store_data_q <= '0;
      out_mem_read_q   <= 1'b0;
      out_mem_write_q  <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      shadow_q         <= '0;
`ifdef MISALIGN_TRAP_EN
      out_exc_q        <= 1'b0;
`endif
    end else begin
      out_valid_q      <= out_valid_d;
      out_result_q     <= out_result_d;
      out_rd_q         <= out_rd_d;
      out_reg_write_q  <= out_reg_write_d;
      out_store_data_q <= out_store_data_d;
      out_mem_read_q   <= out_mem_read_d;
      out_mem_write_q  <= out_mem_write_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      shadow_q         <= shadow_d;
`ifdef MISALIGN_TRAP_EN
      out_exc_q        <= out_exc_d;
`endif
    end
  end

  assign out_valid      = out_valid_q;
  assign out_result     = out_result_q;
  assign out_rd         = out_rd_q;
  assign out_reg_write  = out_reg_write_q;
  assign out_store_data = out_store_data_q;
  assign out_mem_read   = out_mem_read_q;
  assign out_mem_write  = out_mem_write_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
`ifdef MISALIGN_TRAP_EN
  assign out_exc        = out_exc_q;
`endif

endmodule

// File: tb/tb_ex_branch_resolve.sv
// Testbench for ex_branch_resolve: directed scenarios plus random traffic.
// Expected EX/MEM entries and redirects are queued at issue and popped by a monitor.
// Backpressure, flush and mid-stall reset are exercised through out_ready/flush/rst_n.

module tb_ex_branch_resolve;

  localparam int XLEN   = 32;
  localparam int SHADOW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] pc, imm, alu_result, store_data;
  logic [2:0]      funct3;
  logic            is_branch, is_jal, is_jalr;
  logic [3:0]      alu_flags;
  logic [4:0]      rd;
  logic            reg_write, mem_read, mem_write, flush;
  logic            out_valid, out_ready;
  logic [XLEN-1:0] out_result, out_store_data, redirect_pc;
  logic [4:0]      out_rd;
  logic            out_reg_write, out_mem_read, out_mem_write, redirect_valid;
`ifdef MISALIGN_TRAP_EN
  logic            out_exc;
`endif

  always #5 clk = ~clk;

  ex_branch_resolve #(.XLEN(XLEN), .SHADOW(SHADOW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .pc(pc), .imm(imm), .funct3(funct3),
    .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .rd(rd), .reg_write(reg_write), .store_data(store_data),
    .mem_read(mem_read), .mem_write(mem_write), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_reg_write(out_reg_write),
    .out_store_data(out_store_data), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`ifdef MISALIGN_TRAP_EN
    , .out_exc(out_exc)
`endif
  );

  typedef struct packed {
    logic        iv;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [2:0]  f3;
    logic        br, jal, jalr;
    logic [31:0] alu;
    logic [3:0]  fl;
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] sd;
    logic        mr, mw;
    logic        ordy;
    logic        flush;
  } stim_t;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] sd;
    logic        mr, mw, exc;
  } exp_t;

  typedef struct {
    int          cyc;
    logic [31:0] pc;
  } rdr_t;

  exp_t q[$];
  rdr_t rq[$];
  bit   mov;        // model: EX/MEM entry currently held
  int   shadow;     // model: instructions still to be squashed
  bit   drop_held;  // held entry was flushed; retire it from the queue after the edge
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cycle);
    end
  endtask

  task automatic fail_event(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: event not expected by model (cycle %0d)", nm, cycle);
  endtask

  // Monitor: compares the presented entry every cycle (so stalls must hold it),
  // retires it on handshake, and matches redirect pulses to their cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (q.size() == 0) fail_event("unexpected_entry");
        else begin
          check("out_result",     out_result,     q[0].res);
          check("out_rd",         32'(out_rd),    32'(q[0].rd));
          check("out_reg_write",  32'(out_reg_write), 32'(q[0].rw));
          check("out_store_data", out_store_data, q[0].sd);
          check("out_mem_read",   32'(out_mem_read),  32'(q[0].mr));
          check("out_mem_write",  32'(out_mem_write), 32'(q[0].mw));
`ifdef MISALIGN_TRAP_EN
          check("out_exc",        32'(out_exc),   32'(q[0].exc));
`endif
          if (out_ready) void'(q.pop_front());
        end
      end
      if (redirect_valid) begin
        if (rq.size() == 0) fail_event("spurious_redirect");
        else begin
          check("redirect_cycle", 32'(cycle), 32'(rq[0].cyc));
          check("redirect_pc",    redirect_pc, rq[0].pc);
          void'(rq.pop_front());
        end
      end else if (rq.size() != 0 && rq[0].cyc <= cycle) begin
        check("redirect_missing", 32'(redirect_valid), 32'd1);
        void'(rq.pop_front());
      end
    end
  end

  function automatic stim_t idle();
    stim_t s = '0;
    s.ordy = 1'b1;
    return s;
  endfunction

  // cls: 3'b100 branch, 3'b010 JAL, 3'b001 JALR, 3'b000 plain op.
  function automatic stim_t ins(input logic [31:0] p, input logic [31:0] im, input logic [2:0] f3,
                                input logic [2:0] cls, input logic [31:0] alu,
                                input logic [3:0] fl, input logic [4:0] rdv);
    stim_t s = idle();
    s.iv  = 1'b1;
    s.pc  = p;   s.imm = im;  s.f3 = f3;
    {s.br, s.jal, s.jalr} = cls;
    s.alu = alu; s.fl = fl;   s.rd = rdv;
    s.rw  = 1'b1;
    s.sd  = alu ^ 32'h5a5a_0f0f;
    return s;
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    int k;
    s.iv    = ($urandom_range(0, 3) != 0);
    s.pc    = $urandom & 32'hffff_fffc;
    s.imm   = ($urandom_range(0, 3) == 0) ? $urandom : (32'($urandom_range(0, 4095)) - 32'd2048);
    s.f3    = 3'($urandom_range(0, 7));
    k       = $urandom_range(0, 5);
    s.br    = (k == 0);
    s.jal   = (k == 1);
    s.jalr  = (k == 2);
    s.alu   = $urandom;
    s.fl    = 4'($urandom_range(0, 15));
    s.rd    = 5'($urandom_range(0, 31));
    s.rw    = 1'($urandom_range(0, 1));
    s.sd    = $urandom;
    s.mr    = 1'($urandom_range(0, 1));
    s.mw    = 1'($urandom_range(0, 1));
    s.ordy  = ($urandom_range(0, 9) < 7);
    s.flush = ($urandom_range(0, 15) == 0);
    return s;
  endfunction

  // One cycle: check state after the last edge, drive inputs for the next edge,
  // and advance the reference model by the architectural rules.
  task automatic step(input stim_t s);
    exp_t        e;
    logic        cond, taken, mis;
    logic        z, n, v, c;
    logic [31:0] tgt;
    bit          rdy, acc;
    @(posedge clk);
    #1;
    if (drop_held) begin
      void'(q.pop_back());
      drop_held = 0;
    end
    check("out_valid", 32'(out_valid), 32'(mov));
    in_valid   = s.iv;   pc = s.pc;   imm = s.imm;   funct3 = s.f3;
    is_branch  = s.br;   is_jal = s.jal;   is_jalr = s.jalr;
    alu_result = s.alu;  alu_flags = s.fl; rd = s.rd; reg_write = s.rw;
    store_data = s.sd;   mem_read = s.mr;  mem_write = s.mw;
    out_ready  = s.ordy; flush = s.flush;
    #1;
    rdy = !mov || s.ordy;
    check("in_ready", 32'(in_ready), 32'(rdy));
    acc = s.iv && rdy;

    v = s.fl[3]; c = s.fl[2]; n = s.fl[1]; z = s.fl[0];
    case (s.f3)
      3'd0:    cond = z;
      3'd1:    cond = !z;
      3'd4:    cond = (n != v);
      3'd5:    cond = (n == v);
      3'd6:    cond = !c;
      3'd7:    cond = c;
      default: cond = 1'b0;
    endcase
    taken = s.jal || s.jalr || (s.br && cond);
    tgt   = s.jalr ? (s.alu & 32'hffff_fffe) : (s.pc + s.imm);
`ifdef MISALIGN_TRAP_EN
    mis = taken && tgt[1];
`else
    mis = 1'b0;
`endif
    e.res = (s.jal || s.jalr) ? s.pc + 32'd4 : s.alu;
    e.rd  = s.rd;
    e.rw  = s.br ? 1'b0 : s.rw;
    e.sd  = s.sd;
    e.mr  = s.mr;
    e.mw  = s.mw;
    e.exc = mis;
    if (mis) begin
      e.res = tgt;
      e.rw  = 1'b0;
    end

    if (s.flush) begin
      if (mov && !s.ordy) drop_held = 1;
      mov    = 0;
      shadow = 0;
    end else if (acc) begin
      if (shadow > 0) begin
        shadow--;
        mov = 0;
      end else begin
        q.push_back(e);
        mov = 1;
        if (taken && !mis) begin
          rq.push_back('{cycle + 1, tgt});
          shadow = SHADOW;
        end
      end
    end else if (mov && s.ordy) begin
      mov = 0;
    end
  endtask

  task automatic drive_idle();
    stim_t s = idle();
    in_valid = s.iv; pc = '0; imm = '0; funct3 = '0;
    is_branch = 0; is_jal = 0; is_jalr = 0; alu_result = '0; alu_flags = '0;
    rd = '0; reg_write = 0; store_data = '0; mem_read = 0; mem_write = 0;
    out_ready = s.ordy; flush = 0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_out_valid"},      32'(out_valid),      32'd0);
    check({tag, "_redirect_valid"}, 32'(redirect_valid), 32'd0);
    check({tag, "_redirect_pc"},    redirect_pc,         32'd0);
    check({tag, "_out_result"},     out_result,          32'd0);
    check({tag, "_out_rd"},         32'(out_rd),         32'd0);
    check({tag, "_out_reg_write"},  32'(out_reg_write),  32'd0);
    check({tag, "_out_store_data"}, out_store_data,      32'd0);
    check({tag, "_out_mem_rw"},     32'({out_mem_read, out_mem_write}), 32'd0);
`ifdef MISALIGN_TRAP_EN
    check({tag, "_out_exc"},        32'(out_exc),        32'd0);
`endif
  endtask

  initial begin
    stim_t s;
    mov = 0; shadow = 0; drop_held = 0;
    rst_n = 1'b0;
    drive_idle();
    #12;
    check_reset("reset");
    #5 rst_n = 1'b1;

    // Taken BEQ: redirect to 0x120, two squashed accepts, third visible.
    step(ins(32'h100, 32'h20, 3'b000, 3'b100, 32'h0, 4'b0001, 5'd0));
    step(ins(32'h104, 32'h0, 3'b000, 3'b000, 32'h11, 4'b0000, 5'd3));
    step(ins(32'h108, 32'h0, 3'b000, 3'b000, 32'h22, 4'b0000, 5'd4));
    step(ins(32'h10c, 32'h0, 3'b000, 3'b000, 32'h33, 4'b0000, 5'd5));
    // BLT with N=V -> not taken; BLTU with C=0 -> taken.
    step(ins(32'h200, 32'h40, 3'b100, 3'b100, 32'h7, 4'b1010, 5'd6));
    step(ins(32'h204, 32'h80, 3'b110, 3'b100, 32'h8, 4'b0000, 5'd7));
    step(ins(32'h208, 32'h0, 3'b000, 3'b000, 32'h44, 4'b0000, 5'd8));
    step(ins(32'h20c, 32'h0, 3'b000, 3'b000, 32'h55, 4'b0000, 5'd9));
    // JALR: target 0x2002, link 0x44.
    step(ins(32'h40, 32'h0, 3'b000, 3'b001, 32'h2003, 4'b0000, 5'd1));
    step(ins(32'h44, 32'h0, 3'b000, 3'b000, 32'h66, 4'b0000, 5'd2));
    step(ins(32'h48, 32'h0, 3'b000, 3'b000, 32'h77, 4'b0000, 5'd2));
    // Stall three cycles with a held entry, then back-to-back replacement.
    s = ins(32'h300, 32'h0, 3'b000, 3'b000, 32'h88, 4'b0000, 5'd10);
    s.ordy = 1'b0;
    step(s);
    s = ins(32'h304, 32'h0, 3'b000, 3'b000, 32'h99, 4'b0000, 5'd11);
    s.ordy = 1'b0;
    repeat (3) step(s);
    s.ordy = 1'b1;
    step(s);
    step(ins(32'h308, 32'h0, 3'b000, 3'b000, 32'haa, 4'b0000, 5'd12));
    // Taken JAL in a flush cycle: dropped, no redirect, no shadow.
    s = ins(32'h400, 32'h80, 3'b000, 3'b010, 32'h0, 4'b0000, 5'd1);
    s.flush = 1'b1;
    step(s);
    step(ins(32'h404, 32'h0, 3'b000, 3'b000, 32'hbb, 4'b0000, 5'd13));
    // JAL to 0x6: redirect by default, exception entry with the trap enabled.
    step(ins(32'h0, 32'h6, 3'b000, 3'b010, 32'h0, 4'b0000, 5'd1));
    step(ins(32'h4, 32'h0, 3'b000, 3'b000, 32'hcc, 4'b0000, 5'd2));
    step(ins(32'h8, 32'h0, 3'b000, 3'b000, 32'hdd, 4'b0000, 5'd2));
    // Wrap-around of pc+imm.
    step(ins(32'hffff_fff0, 32'h20, 3'b001, 3'b100, 32'h0, 4'b0000, 5'd0));
    step(idle());
    step(idle());

    // Reset while a taken JAL is stalled and its redirect is pending.
    s = ins(32'h500, 32'h100, 3'b000, 3'b010, 32'h0, 4'b0000, 5'd1);
    s.ordy = 1'b0;
    step(s);
    s = idle();
    s.ordy = 1'b0;
    step(s);
    #2 rst_n = 1'b0;
    #1;
    check_reset("midreset");
    q.delete(); rq.delete();
    mov = 0; shadow = 0; drop_held = 0;
    drive_idle();
    #3 rst_n = 1'b1;
    step(ins(32'h600, 32'h0, 3'b000, 3'b000, 32'hee, 4'b0000, 5'd14));

    for (int i = 0; i < 3000; i++) step(rnd());

    repeat (6) step(idle());
    @(negedge clk);
    #1;
    check("entries_left", 32'(q.size()), 32'd0);
    check("redirects_left", 32'(rq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
